// File: rtl/mult_partial_result_combiner.sv
// Resolves the multiplier's partial-result words into lane results, then
// accumulates them over a frame and hands one packed total downstream.
// Stage 1 registers the resolved lanes of each beat; stage 2 holds the running
// frame accumulator and the output registers.
module mult_partial_result_combiner #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [44:0]      result_0,
    input  logic [44:0]      result_1,
    input  logic [7:0]       result_SIDM_carry,
    input  logic [1:0]       mode,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [1:0]       out_mode,
    output logic [CNT_W-1:0] beat_count,
    output logic [3:0]       lane_ovf
);

    localparam logic [1:0] M_27X18 = 2'b00;
    localparam logic [1:0] M_SUM9  = 2'b01;
    localparam logic [1:0] M_SUM4  = 2'b10;

    // ---------------- stage 1: segmented combine ----------------
    logic [44:0] sum00;
    logic [28:0] s01_lo;
    logic [19:0] s01_hi;
    logic [18:0] s10_0;
    logic [11:0] s10_1;
    logic [9:0]  s10_2;
    logic [11:0] s10_3;
    logic [19:0] l01_0, l01_1;
    logic [9:0]  l10_0, l10_1, l10_2, l10_3;
    logic [ACC_W-1:0] lanes_d;

    // Each segment adds on its own; the SIDM carry pair rides on top of r0
    // so the two top bits of every segment sum become the lane's high bits.
    assign sum00  = result_0 + result_1;
    assign s01_lo = {result_SIDM_carry[3:2], result_0[26:0]}  + {2'b00, result_1[26:0]};
    assign s01_hi = {result_SIDM_carry[7:6], result_0[44:27]} + {2'b00, result_1[44:27]};
    assign s10_0  = {result_SIDM_carry[1:0], result_0[16:0]}  + {2'b00, result_1[16:0]};
    assign s10_1  = {result_SIDM_carry[3:2], result_0[26:17]} + {2'b00, result_1[26:17]};
    assign s10_2  = {result_SIDM_carry[5:4], result_0[34:27]} + {2'b00, result_1[34:27]};
    assign s10_3  = {result_SIDM_carry[7:6], result_0[44:35]} + {2'b00, result_1[44:35]};

    assign l01_0 = {s01_lo[28:27], s01_lo[26:9]};
    assign l01_1 = s01_hi;
    assign l10_0 = {s10_0[18:17], s10_0[16:9]};
    assign l10_1 = {s10_1[11:10], s10_1[9:2]};
    assign l10_2 = s10_2;
    assign l10_3 = {s10_3[11:10], s10_3[9:2]};

    // Pack the resolved lanes, sign-extended into their accumulator slots.
    always_comb begin
        lanes_d = '0;
        case (mode)
            M_27X18: lanes_d = {{3{sum00[44]}}, sum00};
            M_SUM9:  lanes_d = {{4{l01_1[19]}}, l01_1, {4{l01_0[19]}}, l01_0};
            M_SUM4:  lanes_d = {{2{l10_3[9]}}, l10_3, {2{l10_2[9]}}, l10_2,
                                {2{l10_1[9]}}, l10_1, {2{l10_0[9]}}, l10_0};
            default: lanes_d = '0;
        endcase
    end

    logic             s1_valid_q;
    logic [ACC_W-1:0] s1_lanes_q;
    logic [1:0]       s1_mode_q;
    logic             s1_first_q, s1_last_q;
    logic             out_valid_q;
    logic             s2_adv, s2_fire, accept;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s2_fire  = s1_valid_q && s2_adv;
    assign in_ready = reset_n && (!s1_valid_q || s2_adv);
    assign accept   = in_valid && in_ready;

    // Stage-1 register: captures a beat on accept, empties when stage 2 takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_lanes_q <= '0;
            s1_mode_q  <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_lanes_q <= lanes_d;
            s1_mode_q  <= mode;
            s1_first_q <= in_first;
            s1_last_q  <= in_last;
        end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // ---------------- stage 2: frame accumulate ----------------
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ovf_q, ovf_d, ovf_beat;
    logic [1:0]       fmode_q, fmode_d, mode_eff;
    logic             open_q, start;

    logic [ACC_W-1:0] acc_out_q;
    logic [1:0]       out_mode_q;
    logic [CNT_W-1:0] beat_count_q;
    logic [3:0]       lane_ovf_q;

    // Exact (one bit wider) lane sums; the extra guard bits show whether the
    // running total has left the lane's native signed range.
    logic [48:0]      e00;
    logic [1:0][24:0] e01;
    logic [3:0][12:0] e10;

    assign e00 = {acc_q[47], acc_q} + {s1_lanes_q[47], s1_lanes_q};
    for (genvar i = 0; i < 2; i++) begin : g_l01
        assign e01[i] = {acc_q[i*24+23], acc_q[i*24 +: 24]}
                      + {s1_lanes_q[i*24+23], s1_lanes_q[i*24 +: 24]};
    end
    for (genvar i = 0; i < 4; i++) begin : g_l10
        assign e10[i] = {acc_q[i*12+11], acc_q[i*12 +: 12]}
                      + {s1_lanes_q[i*12+11], s1_lanes_q[i*12 +: 12]};
    end

    // A beat with no open frame starts one even without in_first.
    assign start    = s1_first_q || !open_q;
    assign mode_eff = start ? s1_mode_q : fmode_q;

    // Per-lane wrapping add in the frame's lane layout, plus headroom check
    // against the native lane width (45 / 20 / 10 bits).
    always_comb begin
        acc_sum  = '0;
        ovf_beat = '0;
        case (mode_eff)
            M_27X18: begin
                acc_sum     = e00[47:0];
                ovf_beat[0] = !((&e00[48:44]) || !(|e00[48:44]));
            end
            M_SUM9: begin
                acc_sum = {e01[1][23:0], e01[0][23:0]};
                for (int i = 0; i < 2; i++)
                    ovf_beat[i] = !((&e01[i][24:19]) || !(|e01[i][24:19]));
            end
            M_SUM4: begin
                acc_sum = {e10[3][11:0], e10[2][11:0], e10[1][11:0], e10[0][11:0]};
                for (int i = 0; i < 4; i++)
                    ovf_beat[i] = !((&e10[i][12:9]) || !(|e10[i][12:9]));
            end
            default: begin
                acc_sum  = '0;
                ovf_beat = '0;
            end
        endcase
    end

    // Frame state including the beat currently leaving stage 1.
    always_comb begin
        if (start) begin
            acc_d   = s1_lanes_q;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            ovf_d   = '0;
            fmode_d = s1_mode_q;
        end else begin
            acc_d   = acc_sum;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            ovf_d   = ovf_q | ovf_beat;
            fmode_d = fmode_q;
        end
    end

    // Accumulator and output registers; a last beat publishes the total and closes the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= '0;
            fmode_q      <= '0;
            open_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            acc_out_q    <= '0;
            out_mode_q   <= '0;
            beat_count_q <= '0;
            lane_ovf_q   <= '0;
        end else begin
            if (s2_fire) begin
                if (s1_last_q) begin
                    out_valid_q  <= 1'b1;
                    acc_out_q    <= acc_d;
                    out_mode_q   <= fmode_d;
                    beat_count_q <= cnt_d;
                    lane_ovf_q   <= ovf_d;
                    open_q       <= 1'b0;
                    acc_q        <= '0;
                    cnt_q        <= '0;
                    ovf_q        <= '0;
                end else begin
                    open_q  <= 1'b1;
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_d;
                    ovf_q   <= ovf_d;
                    fmode_q <= fmode_d;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign acc_out    = acc_out_q;
    assign out_mode   = out_mode_q;
    assign beat_count = beat_count_q;
    assign lane_ovf   = lane_ovf_q;

endmodule

// File: tb/tb_mult_partial_result_combiner.sv
// Directed bench for the partial-result combiner: per-mode lane resolution,
// frame accumulation, wrap flags, backpressure and mid-frame reset.
module tb_mult_partial_result_combiner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [44:0] result_0, result_1;
    logic [7:0]  result_SIDM_carry;
    logic [1:0]  mode;
    logic        in_first, in_last;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] acc_out;
    logic [1:0]  out_mode;
    logic [15:0] beat_count;
    logic [3:0]  lane_ovf;

    int checks = 0;
    int errors = 0;

    mult_partial_result_combiner #(.ACC_W(48), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .result_0(result_0), .result_1(result_1),
        .result_SIDM_carry(result_SIDM_carry), .mode(mode),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .out_mode(out_mode),
        .beat_count(beat_count), .lane_ovf(lane_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one beat; accepted on the first rising edge with in_ready high.
    task automatic send(input logic [44:0] r0, input logic [44:0] r1, input logic [7:0] c,
                        input logic [1:0] m, input logic f, input logic l);
        int n;
        @(negedge clk);
        result_0 = r0; result_1 = r1; result_SIDM_carry = c;
        mode = m; in_first = f; in_last = l; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_rdy", {63'd0, in_ready}, 64'd1);
        if (in_ready) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a frame total, compare it, and let it be consumed.
    task automatic wait_out(input string tag, input int maxw, input logic [47:0] e_acc,
                            input logic [1:0] e_mode, input logic [15:0] e_cnt,
                            input logic [3:0] e_ovf);
        int n;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < maxw) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
        if (out_valid) begin
            chk({tag, "_acc"},  {16'd0, acc_out},    {16'd0, e_acc});
            chk({tag, "_mode"}, {62'd0, out_mode},   {62'd0, e_mode});
            chk({tag, "_cnt"},  {48'd0, beat_count}, {48'd0, e_cnt});
            chk({tag, "_ovf"},  {60'd0, lane_ovf},   {60'd0, e_ovf});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        result_0 = '0; result_1 = '0; result_SIDM_carry = '0;
        mode = '0; in_first = 1'b0; in_last = 1'b0;

        #2;
        chk("rst_vld",  {63'd0, out_valid}, 64'd0);
        chk("rst_rdy",  {63'd0, in_ready},  64'd0);
        chk("rst_acc",  {16'd0, acc_out},   64'd0);
        chk("rst_cnt",  {48'd0, beat_count}, 64'd0);
        chk("rst_ovf",  {60'd0, lane_ovf},  64'd0);
        chk("rst_mode", {62'd0, out_mode},  64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Mode 00 single beat: 100 + 23, visible two edges after acceptance.
        send(45'd100, 45'd23, 8'h00, 2'b00, 1'b1, 1'b1);
        @(negedge clk);
        chk("lat_t1", {63'd0, out_valid}, 64'd0);
        wait_out("m00_single", 0, 48'd123, 2'b00, 16'd1, 4'b0000);

        // Mode 00 three beats of (-5 + 2) = -3 each -> -9.
        send(45'h1FFF_FFFF_FFFB, 45'd2, 8'h00, 2'b00, 1'b1, 1'b0);
        send(45'h1FFF_FFFF_FFFB, 45'd2, 8'h00, 2'b00, 1'b0, 1'b0);
        send(45'h1FFF_FFFF_FFFB, 45'd2, 8'h00, 2'b00, 1'b0, 1'b1);
        wait_out("m00_signed", 50, 48'hFFFF_FFFF_FFF7, 2'b00, 16'd3, 4'b0000);

        // Mode 01 lane 0 with carry pair 01: {01, 0x400[26:9]} = 0x40002.
        send(45'h200, 45'h200, 8'h04, 2'b01, 1'b1, 1'b1);
        wait_out("m01_lane0", 50, 48'h000000_040002, 2'b01, 16'd1, 4'b0000);

        // Mode 01 lane 1 carry pair 11 alone: 20'hC0000 -> sign-extended 24'hFC0000.
        send(45'h0, 45'h0, 8'hC0, 2'b01, 1'b1, 1'b1);
        wait_out("m01_lane1", 50, 48'hFC0000_000000, 2'b01, 16'd1, 4'b0000);

        // Mode 10 lane 3: {01, FF} = 0x1FF per beat, x3 = 0x5FD, leaves 10-bit range.
        send(45'hFF << 37, 45'h0, 8'h40, 2'b10, 1'b1, 1'b0);
        send(45'hFF << 37, 45'h0, 8'h40, 2'b10, 1'b0, 1'b0);
        send(45'hFF << 37, 45'h0, 8'h40, 2'b10, 1'b0, 1'b1);
        wait_out("m10_wrap", 50, 48'h5FD_000_000_000, 2'b10, 16'd3, 4'b1000);

        // Mode 10 segment 0 overflow must not spill into segment 1: lane0 = 0x100.
        send(45'h1FFFF, 45'h1, 8'h00, 2'b10, 1'b1, 1'b1);
        wait_out("m10_iso", 50, 48'h000_000_000_100, 2'b10, 16'd1, 4'b0000);

        // Reserved mode: accepted, contributes zero.
        send(45'd100, 45'd5, 8'hFF, 2'b11, 1'b1, 1'b1);
        wait_out("m11_zero", 50, 48'd0, 2'b11, 16'd1, 4'b0000);

        // Beat without in_first and no open frame starts a fresh frame.
        send(45'd7, 45'd0, 8'h00, 2'b00, 1'b0, 1'b1);
        wait_out("orphan", 50, 48'd7, 2'b00, 16'd1, 4'b0000);

        // Backpressure: two frames fill output and stage 1, then input stalls.
        out_ready = 1'b0;
        send(45'd1, 45'd0, 8'h00, 2'b00, 1'b1, 1'b1);
        send(45'd2, 45'd0, 8'h00, 2'b00, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_rdy",  {63'd0, in_ready},  64'd0);
        chk("bp_vld",  {63'd0, out_valid}, 64'd1);
        chk("bp_acc",  {16'd0, acc_out},   64'd1);
        fork
            begin
                send(45'd3, 45'd0, 8'h00, 2'b00, 1'b1, 1'b1);
                send(45'd4, 45'd0, 8'h00, 2'b00, 1'b1, 1'b1);
            end
        join_none
        repeat (3) @(negedge clk);
        chk("bp_hold_acc", {16'd0, acc_out},  64'd1);
        chk("bp_hold_rdy", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_out("bp_f1", 50, 48'd1, 2'b00, 16'd1, 4'b0000);
        wait_out("bp_f2", 50, 48'd2, 2'b00, 16'd1, 4'b0000);
        wait_out("bp_f3", 50, 48'd3, 2'b00, 16'd1, 4'b0000);
        wait_out("bp_f4", 50, 48'd4, 2'b00, 16'd1, 4'b0000);
        repeat (4) @(negedge clk);
        chk("bp_nodup", {63'd0, out_valid}, 64'd0);

        // Reset in the middle of a 3-beat frame.
        send(45'd1000, 45'd0, 8'h00, 2'b00, 1'b1, 1'b0);
        send(45'd1000, 45'd0, 8'h00, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mrst_vld", {63'd0, out_valid},  64'd0);
        chk("mrst_acc", {16'd0, acc_out},    64'd0);
        chk("mrst_cnt", {48'd0, beat_count}, 64'd0);
        chk("mrst_rdy", {63'd0, in_ready},   64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send(45'd5, 45'd0, 8'h00, 2'b00, 1'b0, 1'b1);
        wait_out("post_rst", 50, 48'd5, 2'b00, 16'd1, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
